marker_cluster: RTL

- Downstream of the per-row flip counter.
- Consumes its per-row target detections (done pulse, centre coordinate, centre width, not-target probability) together with the current row number.
- Groups vertically consecutive detections with consistent x into clusters, and keeps the strongest cluster of the frame.
- At end of frame, reports one marker centre (x, y) plus its size and hit count to the tracking/overlay logic.

---
 rtl/marker_pkg.sv | 37 +++
 rtl/marker_cluster_compare.sv | 32 +++
 rtl/marker_cluster.sv | 136 +++++++++++++
 3 files changed

// File: rtl/marker_pkg.sv
// Shared types and widths for the marker clustering block.
package marker_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int MAX_WIDTH     = 150;
  localparam int NT_THRES      = 40;
  localparam int X_TOL         = 8;
  localparam int MAX_ROW_GAP   = 3;
  localparam int MIN_HITS      = 4;

  localparam int XW  = $clog2(SCREEN_WIDTH) + 1;
  localparam int YW  = $clog2(SCREEN_HEIGHT) + 1;
  localparam int WW  = $clog2(MAX_WIDTH) + 1;
  localparam int NTW = 11;

  typedef enum logic [1:0] {IDLE, TRACK, REPORT} state_t;

  typedef struct packed {
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [XW-1:0] x_last;
    logic [YW-1:0] first_row;
    logic [YW-1:0] last_row;
    logic [YW-1:0] hits;
    logic [WW-1:0] width;
  } cluster_t;

  function automatic logic [XW-1:0] absdiff_x(input logic [XW-1:0] a, input logic [XW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [YW-1:0] absdiff_y(input logic [YW-1:0] a, input logic [YW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/marker_cluster_compare.sv
// Commit eligibility of a candidate cluster against the frame's best cluster.
// Build with MARKER_ROUNDNESS_CHECK_EN to also require height ~= max centre width.
module cluster_compare
  import marker_pkg::*;
(
  input  logic     eval,
  input  cluster_t cand,
  input  cluster_t best,
  output logic     commit,
  output cluster_t best_sel
);

  logic round_ok;

`ifdef MARKER_ROUNDNESS_CHECK_EN
  logic [YW-1:0] height;
  logic [YW-1:0] wid_y;
  logic [YW-1:0] hdiff;

  assign height   = cand.last_row - cand.first_row + YW'(1);
  assign wid_y    = YW'(cand.width);
  assign hdiff    = absdiff_y(height, wid_y);
  assign round_ok = hdiff < (wid_y >> 2);
`else
  assign round_ok = 1'b1;
`endif

  // Strictly greater keeps the earlier cluster on a tie.
  assign commit   = eval && (cand.hits >= YW'(MIN_HITS)) && (cand.hits > best.hits) && round_ok;
  assign best_sel = commit ? cand : best;

endmodule

// File: rtl/marker_cluster.sv
// Groups per-row detections into vertical clusters and reports the best one per frame.
// Optional roundness gate: MARKER_ROUNDNESS_CHECK_EN (see cluster_compare).
//   state  | meaning
//   IDLE   | no open cluster
//   TRACK  | cluster open, extending with nearby rows
//   REPORT | one cycle: publish best cluster, clear everything
module marker_cluster
  import marker_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [YW-1:0]  vcount_in,
  input  logic           done_in,
  input  logic [XW-1:0]  coord_in,
  input  logic [WW-1:0]  centre_width_in,
  input  logic [NTW-1:0] nt_probability_in,
  input  logic           frame_end_in,
  output logic           marker_valid_out,
  output logic           marker_found_out,
  output logic [XW-1:0]  marker_x_out,
  output logic [YW-1:0]  marker_y_out,
  output logic [WW-1:0]  marker_width_out,
  output logic [YW-1:0]  marker_hits_out
);

  state_t   state, state_next;
  cluster_t cl, cl_next, best, best_sel, cand, fresh, joined;
  logic     row_hit, row_hit_eff, acc, joins, near, eval, commit;
  logic [YW-1:0] last_vcount;
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;

  assign row_hit_eff = row_hit && (vcount_in == last_vcount);
  assign acc   = done_in && (nt_probability_in <= NTW'(NT_THRES)) && !row_hit_eff
                 && (state != REPORT);
  // A row number below last_row means vcount wrapped: treated as a gap.
  assign near  = (vcount_in >= cl.last_row) && ((vcount_in - cl.last_row) <= YW'(MAX_ROW_GAP));
  assign joins = (absdiff_x(coord_in, cl.x_last) < XW'(X_TOL)) && near;

  always_comb begin
    fresh.x_min     = coord_in;
    fresh.x_max     = coord_in;
    fresh.x_last    = coord_in;
    fresh.first_row = vcount_in;
    fresh.last_row  = vcount_in;
    fresh.hits      = YW'(1);
    fresh.width     = centre_width_in;

    joined          = cl;
    joined.x_min    = (coord_in < cl.x_min) ? coord_in : cl.x_min;
    joined.x_max    = (coord_in > cl.x_max) ? coord_in : cl.x_max;
    joined.x_last   = coord_in;
    joined.last_row = vcount_in;
    joined.hits     = (&cl.hits) ? cl.hits : cl.hits + YW'(1);
    joined.width    = (centre_width_in > cl.width) ? centre_width_in : cl.width;

    state_next = state;
    cl_next    = cl;
    cand       = cl;
    eval       = 1'b0;
    unique case (state)
      IDLE: begin
        cand = acc ? fresh : '0;
        if (acc) begin
          cl_next    = fresh;
          state_next = TRACK;
        end
      end
      TRACK: begin
        if (acc && joins) begin
          cl_next = joined;
          cand    = joined;
        end else if (acc) begin
          eval    = 1'b1;
          cl_next = fresh;
        end else if (!near) begin
          eval       = 1'b1;
          state_next = IDLE;
        end
      end
      REPORT: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (frame_end_in && (state != REPORT)) begin
      eval       = 1'b1;
      state_next = REPORT;
    end
  end

  cluster_compare u_compare (
    .eval     (eval),
    .cand     (cand),
    .best     (best),
    .commit   (commit),
    .best_sel (best_sel)
  );

  assign x_sum = {1'b0, best.x_min} + {1'b0, best.x_max};
  assign y_sum = {1'b0, best.first_row} + {1'b0, best.last_row};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IDLE;
      cl               <= '0;
      best             <= '0;
      row_hit          <= 1'b0;
      last_vcount      <= '0;
      marker_valid_out <= 1'b0;
      marker_found_out <= 1'b0;
      marker_x_out     <= '0;
      marker_y_out     <= '0;
      marker_width_out <= '0;
      marker_hits_out  <= '0;
    end else begin
      state            <= state_next;
      last_vcount      <= vcount_in;
      row_hit          <= acc || row_hit_eff;
      marker_valid_out <= 1'b0;
      if (state == REPORT) begin
        marker_valid_out <= 1'b1;
        marker_found_out <= (best.hits != '0);
        marker_x_out     <= XW'(x_sum >> 1);
        marker_y_out     <= YW'(y_sum >> 1);
        marker_width_out <= best.width;
        marker_hits_out  <= best.hits;
        cl               <= '0;
        best             <= '0;
      end else begin
        cl   <= cl_next;
        best <= best_sel;
      end
    end
  end

endmodule
